// File: rtl/ft232h_ram_dma_master_if.sv
// ft232h_ram_dma_master_if: byte-wide Avalon-MM bus between the DMA master and a RAM slave
// Signals: address, chipselect, read, write, writedata (master -> slave); readdata, waitrequest (slave -> master)
interface ft232h_ram_dma_master_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] address;
  logic chipselect, read, write, waitrequest;
  logic [7:0] writedata, readdata;
  modport master(output address, chipselect, read, write, writedata, input readdata, waitrequest);
  modport slave(input address, chipselect, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/ft232h_ram_dma_master.sv
// ft232h_ram_dma_master: DMA between byte streams and an Avalon-MM RAM
// Ports: clk, reset (async, active-high); cmd_valid/cmd_ready/cmd_dir/cmd_addr/cmd_len command
// handshake (dir 0 = sink to RAM, 1 = RAM to source); done pulse; avm master bus; snk_* byte sink;
// src_* byte source; cksum. Define FT232H_DMA_CKSUM_EN for the mod-256 byte checksum, else cksum = 0.
module ft232h_ram_dma_master #(
  parameter int ADDR_W = 16,
  parameter int LEN_W = 17,
  parameter int RD_LATENCY = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              done,
  ft232h_ram_dma_master_if.master avm,
  input  logic [7:0]        snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [7:0]        src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [7:0]        cksum
);
  localparam logic [2:0] IDLE = 3'd0, WRITE = 3'd1, READ = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] rem;
  logic [RD_LATENCY-1:0] pipe;
  logic [2:0] pend, cnt;
  logic [1:0] wp, rp;
  logic [7:0] mem [4];
  logic accept, wr_acc, rd_acc, ret, pop;
  // gated by reset so the command port reads busy while reset is held
  assign cmd_ready = state == IDLE && !reset;
  assign accept = cmd_valid && cmd_ready;
  assign done = state == DONE;
  assign avm.write = state == WRITE && snk_valid;
  assign avm.writedata = snk_data;
  assign snk_ready = state == WRITE && !avm.waitrequest;
  // in-flight reads plus buffered bytes never exceed the 4 FIFO slots
  assign avm.read = state == READ && pend + cnt < 3'd4;
  assign avm.chipselect = avm.read || avm.write;
  assign avm.address = addr;
  assign wr_acc = avm.write && !avm.waitrequest;
  assign rd_acc = avm.read && !avm.waitrequest;
  assign ret = pipe[RD_LATENCY-1];
  assign src_valid = cnt != 3'd0;
  assign src_data = mem[rp];
  assign pop = src_valid && src_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      pipe <= '0;
      pend <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      pipe <= RD_LATENCY'({pipe, rd_acc});
      pend <= pend + 3'(rd_acc) - 3'(ret);
      cnt <= cnt + 3'(ret) - 3'(pop);
      if (ret) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      if (wr_acc || rd_acc) begin
        addr <= addr + ADDR_W'(1);
        rem <= rem - LEN_W'(1);
      end
      case (state)
        IDLE: if (accept) begin
          addr <= cmd_addr;
          rem <= cmd_len;
          state <= cmd_len == '0 ? DONE : cmd_dir ? READ : WRITE;
        end
        WRITE: if (wr_acc && rem == LEN_W'(1)) state <= DONE;
        READ: if (rd_acc && rem == LEN_W'(1)) state <= DRAIN;
        // leave as the final byte is popped so done follows the last transfer by one cycle
        DRAIN: if (pend == 3'd0 && cnt == 3'(pop)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (ret) mem[wp] <= avm.readdata;
`ifdef FT232H_DMA_CKSUM_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) cksum <= '0;
    else if (accept) cksum <= '0;
    else if (wr_acc) cksum <= cksum + snk_data;
    else if (pop) cksum <= cksum + src_data;
`else
  assign cksum = '0;
`endif
endmodule

// File: tb/tb_ft232h_ram_dma_master.sv
// tb_ft232h_ram_dma_master: randomized bench with a RAM slave and a transaction-level reference model
module tb_ft232h_ram_dma_master;
  localparam int LAT = 2;
`ifdef FT232H_DMA_CKSUM_EN
  localparam bit CK_EN = 1;
`else
  localparam bit CK_EN = 0;
`endif
  typedef struct {logic [7:0] d; int t;} ent_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_dir = 0, done;
  logic [15:0] cmd_addr = 0;
  logic [16:0] cmd_len = 0;
  logic [7:0] snk_data = 0, src_data, cksum;
  logic snk_valid = 0, snk_ready, src_valid, src_ready = 0;
  ft232h_ram_dma_master_if #(.ADDR_W(16)) avm();
  ft232h_ram_dma_master #(.ADDR_W(16), .LEN_W(17), .RD_LATENCY(LAT)) dut(
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .done(done), .avm(avm),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .cksum(cksum));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int wreq_pct = 0, snkv_pct = 100, srcr_pct = 100;
  logic [7:0] ram [65536];
  logic [7:0] sink_tab [64];
  int rs_cyc [8];
  logic [7:0] rs_dat [8];
  bit busy = 0, mdir = 0, done_now = 0, nd, e_wr, e_rd, e_sv;
  logic [15:0] maddr = 0;
  logic [7:0] cks = 0;
  int left = 0, xleft = 0, issued = 0, popped = 0, snk_acc = 0, d_iss = 0, d_pop = 0, mo = 0;
  ent_t fq [$];
  int wl_a [$], wl_d [$], wl_c [$], st_a [$], st_d [$], rl_a [$], pl_d [$];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  // stimulus and RAM slave driven away from the clock edge
  always @(posedge clk) begin
    #2;
    avm.waitrequest = $urandom_range(99) < wreq_pct;
    snk_valid = $urandom_range(99) < snkv_pct;
    snk_data = sink_tab[snk_acc % 64];
    src_ready = $urandom_range(99) < srcr_pct;
    avm.readdata = rs_cyc[cyc % 8] == cyc ? rs_dat[cyc % 8] : 8'($urandom);
  end
  // reference model: transfer bookkeeping in terms of accepted bytes and popped bytes
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctrl", {cmd_ready, done, avm.read, avm.write, avm.chipselect, src_valid, snk_ready}, 0);
      chk("rst_addr", avm.address, 0);
      chk("rst_cksum", cksum, 0);
      busy = 0; done_now = 0; issued = 0; popped = 0; d_iss = 0; d_pop = 0; cks = 0;
      fq.delete();
    end else begin
      e_wr = busy && !mdir && left > 0 && snk_valid;
      e_rd = busy && mdir && left > 0 && issued - popped < 4;
      e_sv = fq.size() > 0 && fq[0].t <= cyc;
      chk("cmd_ready", cmd_ready, !busy);
      chk("done", done, done_now);
      chk("snk_ready", snk_ready, busy && !mdir && left > 0 && !avm.waitrequest);
      chk("avm_write", avm.write, e_wr);
      chk("avm_read", avm.read, e_rd);
      chk("chipselect", avm.chipselect, e_wr || e_rd);
      if (e_wr || e_rd) chk("avm_address", avm.address, maddr);
      if (e_wr) chk("writedata", avm.writedata, sink_tab[snk_acc % 64]);
      chk("src_valid", src_valid, e_sv);
      if (e_sv) chk("src_data", src_data, fq[0].d);
      chk("cksum", cksum, CK_EN ? cks : 8'h0);
      if (avm.write && !avm.waitrequest) begin wl_a.push_back(avm.address); wl_d.push_back(avm.writedata); wl_c.push_back(cyc); end
      if (avm.write && avm.waitrequest) begin st_a.push_back(avm.address); st_d.push_back(avm.writedata); end
      if (avm.read && !avm.waitrequest) begin rl_a.push_back(avm.address); d_iss++; end
      if (src_valid && src_ready) begin pl_d.push_back(src_data); d_pop++; end
      nd = 0;
      if (done_now) busy = 0;
      else if (!busy && cmd_valid) begin
        busy = 1; mdir = cmd_dir; maddr = cmd_addr; left = cmd_len; xleft = cmd_len; cks = 0;
        nd = cmd_len == 0;
      end
      if (e_wr && !avm.waitrequest) begin
        ram[maddr] = sink_tab[snk_acc % 64];
        cks += sink_tab[snk_acc % 64];
        snk_acc++; maddr++; left--; xleft--;
        nd = xleft == 0;
      end
      if (e_rd && !avm.waitrequest) begin
        rs_cyc[(cyc + LAT) % 8] = cyc + LAT;
        rs_dat[(cyc + LAT) % 8] = ram[maddr];
        fq.push_back('{ram[maddr], cyc + LAT + 1});
        maddr++; left--; issued++;
      end
      if (e_sv && src_ready) begin
        cks += fq[0].d;
        void'(fq.pop_front());
        popped++; xleft--;
        nd = xleft == 0;
      end
      done_now = nd;
    end
  end
  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 3000 && dc < 0; i++) begin
      @(negedge clk);
      if (d_iss - d_pop > mo) mo = d_iss - d_pop;
      if (done === 1'b1) dc = cyc;
    end
    if (dc < 0) begin
      chk("done_timeout", 0, 1);
      dc = cyc;
    end
  endtask
  task automatic wait_acc();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) break;
    end
  endtask
  // offers a command, keeps garbage commands valid while busy, returns accept and done cycles
  task automatic run(input bit d, input int a, input int len, output int ac, output int dc);
    @(posedge clk); #1;
    cmd_valid = 1; cmd_dir = d; cmd_addr = 16'(a); cmd_len = 17'(len);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    ac = cyc;
    @(posedge clk); #1;
    cmd_dir = 1'($urandom); cmd_addr = 16'($urandom); cmd_len = 17'($urandom_range(30));
    wait_done(dc);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask
  int ac, dc, w0, r0, p0, s0;
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) sink_tab[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) rs_cyc[i] = -1;
    avm.waitrequest = 0;
    avm.readdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_src_valid", src_valid, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    // write 01..04 to 0x0010
    for (int i = 0; i < 4; i++) sink_tab[(snk_acc + i) % 64] = 8'(i + 1);
    w0 = wl_a.size();
    run(0, 'h10, 4, ac, dc);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", wl_a[w0 + i], 'h10 + i);
      chk("wr_data", wl_d[w0 + i], i + 1);
      chk("wr_cycle", wl_c[w0 + i], ac + 1 + i);
    end
    chk("wr_done_latency", dc - ac, 5);
    chk("wr_cksum_held", cksum, CK_EN ? 'h0A : 0);
    // read across the top of the address space
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB; ram[16'h0000] = 8'hCC; ram[16'h0001] = 8'hDD;
    r0 = rl_a.size(); p0 = pl_d.size();
    run(1, 'hFFFE, 4, ac, dc);
    chk("wrap_addr0", rl_a[r0], 'hFFFE);
    chk("wrap_addr1", rl_a[r0 + 1], 'hFFFF);
    chk("wrap_addr2", rl_a[r0 + 2], 'h0000);
    chk("wrap_addr3", rl_a[r0 + 3], 'h0001);
    chk("wrap_b0", pl_d[p0], 'hAA);
    chk("wrap_b1", pl_d[p0 + 1], 'hBB);
    chk("wrap_b2", pl_d[p0 + 2], 'hCC);
    chk("wrap_b3", pl_d[p0 + 3], 'hDD);
    chk("rd_done_latency", dc - ac, 4 + LAT + 2);
    chk("rd_cksum", cksum, CK_EN ? 'h0E : 0);
    // zero length
    w0 = wl_a.size(); r0 = rl_a.size();
    run(1, 'h1234, 0, ac, dc);
    chk("len0_done", dc - ac, 1);
    chk("len0_no_writes", wl_a.size(), w0);
    chk("len0_no_reads", rl_a.size(), r0);
    // 16-byte read with the source stalled for 10 cycles
    srcr_pct = 0; mo = 0; p0 = pl_d.size();
    fork
      run(1, 'h2000, 16, ac, dc);
      begin
        wait_acc();
        repeat (10) @(posedge clk);
        #1 srcr_pct = 100;
      end
    join
    chk("bp_max_outstanding", mo, 4);
    chk("bp_delivered", pl_d.size() - p0, 16);
    // waitrequest held for 3 cycles during a write
    for (int i = 0; i < 6; i++) sink_tab[(snk_acc + i) % 64] = 8'('h11 + i);
    w0 = wl_a.size(); s0 = st_a.size();
    fork
      run(0, 'h0100, 6, ac, dc);
      begin
        wait_acc();
        repeat (3) @(posedge clk);
        #1 wreq_pct = 100;
        repeat (3) @(posedge clk);
        #1 wreq_pct = 0;
      end
    join
    chk("stall_count", st_a.size() - s0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", st_a[s0 + i], 'h0102);
      chk("stall_data", st_d[s0 + i], 'h13);
    end
    for (int i = 0; i < 6; i++) begin
      chk("wait_wr_addr", wl_a[w0 + i], 'h100 + i);
      chk("wait_wr_data", wl_d[w0 + i], 'h11 + i);
    end
    // reset in the middle of a read
    srcr_pct = 50;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_dir = 1; cmd_addr = 16'h3000; cmd_len = 17'd16;
    @(negedge clk);
    chk("mid_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_ctrl", {cmd_ready, done, avm.read, avm.write, avm.chipselect, src_valid, snk_ready}, 0);
    chk("mid_rst_addr", avm.address, 0);
    chk("mid_rst_cksum", cksum, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 0;
    srcr_pct = 100; p0 = pl_d.size();
    run(1, 'h4000, 8, ac, dc);
    chk("post_rst_delivered", pl_d.size() - p0, 8);
    chk("post_rst_latency", dc - ac, 8 + LAT + 2);
    // randomized commands
    for (int n = 0; n < 30; n++) begin
      wreq_pct = $urandom_range(50);
      snkv_pct = $urandom_range(100, 30);
      srcr_pct = $urandom_range(100, 30);
      run(1'($urandom), int'($urandom_range(65535)), $urandom_range(7) == 0 ? 0 : int'($urandom_range(24, 1)), ac, dc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
